// File: rtl/cpu_bus_rw.sv
// cpu_bus_rw: turns a read/write burst command into single-beat
// request/acknowledge transactions on a simple CPU bus.
// A write burst fetches each beat from the wr_* stream before requesting it.
// A read burst returns each beat on rd_data/rd_valid.
// Every beat's request is bounded by a timeout. On timeout the rest of the burst
// is dropped and done+err are pulsed.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write burst, 0 = read burst
//   cmd_addr              start address
//   cmd_len               beats minus one
//   wr_data/wr_valid/     write beat stream
//   wr_ready
//   rd_data/rd_valid      read beat data, one-cycle pulse per beat
//   bus_req/bus_we/       bus request side
//   bus_addr/bus_wdata
//   bus_ack/bus_rdata     bus response side
//   done                  one-cycle end-of-burst pulse
//   err                   one-cycle timeout pulse, always together with done
module cpu_bus_rw #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [WORD_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [WORD_WIDTH-1:0] bus_rdata,
    output logic                  done,
    output logic                  err
);

    // Counter must be able to hold TIMEOUT itself.
    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [LEN_WIDTH-1:0] remaining;
    logic [CNT_W-1:0]     tmo_cnt;

    logic accept;
    logic wr_take;
    logic ack_hit;
    logic timeout_hit;

    logic cmd_ready_d;
    logic wr_ready_d;
    logic bus_req_d;
    logic done_d;
    logic err_d;

    // Handshake and bus events qualified by the current state.
    assign accept      = (state == S_IDLE) && cmd_ready && cmd_valid;
    assign wr_take     = (state == S_FETCH) && wr_ready && wr_valid;
    assign ack_hit     = (state == S_REQ) && bus_ack;
    // This is the last permitted wait cycle. An ack arriving in the same cycle still wins.
    assign timeout_hit = (state == S_REQ) && !bus_ack
                         && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = cmd_write ? S_FETCH : S_REQ;
                end
            end
            S_FETCH: begin
                if (wr_take) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_hit) begin
                    state_next = (remaining == '0) ? S_DONE : S_GAP;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_GAP:   state_next = bus_we ? S_FETCH : S_REQ;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode. Bus-side and wr_ready use the next state, so the registered
    // values line up with the state itself. done/err/cmd_ready use the current
    // state, so they appear one cycle after DONE/ERR.
    always_comb begin
        cmd_ready_d = 1'b0;
        wr_ready_d  = 1'b0;
        bus_req_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        // cmd_ready must drop as soon as a command is taken, and must not rise
        // before IDLE has been reached.
        cmd_ready_d = (state == S_IDLE) && (state_next == S_IDLE);
        wr_ready_d  = (state_next == S_FETCH);
        bus_req_d   = (state_next == S_REQ);
        done_d      = (state == S_DONE) || (state == S_ERR);
        err_d       = (state == S_ERR);
    end

    // Registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            bus_req   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_d;
            wr_ready  <= wr_ready_d;
            bus_req   <= bus_req_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Burst datapath: address, beat count, write data and read return
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            remaining <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (accept) begin
                bus_we    <= cmd_write;
                bus_addr  <= cmd_addr;
                remaining <= cmd_len;
            end
            if (wr_take) begin
                bus_wdata <= wr_data;
            end
            if (ack_hit) begin
                // Address arithmetic wraps naturally at the width of bus_addr.
                bus_addr <= bus_addr + ADDR_WIDTH'(ADDR_STEP);
                if (remaining != '0) begin
                    remaining <= remaining - LEN_WIDTH'(1);
                end
            end
            rd_valid <= ack_hit && !bus_we;
            if (ack_hit && !bus_we) begin
                rd_data <= bus_rdata;
            end
        end
    end

    // Wait counter: runs only while a request is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == S_REQ) && !bus_ack) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_bus_rw.sv
// Directed bench for cpu_bus_rw. A scripted bus slave acks after a set delay.
// Expected bus requests and read data are queued as stimulus is issued, and are
// popped when the DUT shows them.
module tb_cpu_bus_rw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    cpu_bus_rw #(
        .WORD_WIDTH(32),
        .ADDR_WIDTH(32),
        .LEN_WIDTH (4),
        .ADDR_STEP (4),
        .TIMEOUT   (255)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          gap;   // expected idle cycles before this request, 0 = unchecked
    } exp_req_t;

    exp_req_t    exp_req[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rsp_rd[$];
    logic [31:0] wr_q[$];
    exp_req_t    cur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_rd_cyc = 0;
    int last_done_cyc = 0;
    int last_err_cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int req_wait = 0;
    int low_run = 0;
    int ack_delay = 0;
    bit ack_en = 1'b1;
    bit ack_idle = 1'b0;
    bit hold_wr = 1'b0;
    logic req_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive the slave and write stream.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        if (rd_valid) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            check("rd_expected", 64'(exp_rd.size() > 0), 64'(1));
            if (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                check("rd_data", 64'(rd_data), 64'(e));
            end
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (err) begin
            err_cnt++;
            last_err_cyc = cyc;
            check("err_with_done", 64'(done), 64'(1));
        end
        if (bus_req && !req_prev) begin
            check("req_expected", 64'(exp_req.size() > 0), 64'(1));
            if (exp_req.size() > 0) begin
                cur = exp_req.pop_front();
                check("bus_addr", 64'(bus_addr), 64'(cur.addr));
                check("bus_we", 64'(bus_we), 64'(cur.we));
                if (cur.we) check("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
                if (cur.gap > 0) check("req_gap", 64'(low_run), 64'(cur.gap));
            end
            req_wait = 0;
        end else if (bus_req) begin
            check("addr_stable", 64'(bus_addr), 64'(cur.addr));
        end
        low_run = bus_req ? 0 : low_run + 1;

        bus_ack = 1'b0;
        if (ack_idle) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'hBAD0_BAD0;
        end else if (bus_req && ack_en && req_wait == ack_delay) begin
            bus_ack   = 1'b1;
            bus_rdata = (rsp_rd.size() > 0) ? rsp_rd.pop_front() : 32'h0;
        end
        if (bus_req) req_wait++;
        req_prev = bus_req;

        wr_valid = 1'b0;
        if (!hold_wr && wr_q.size() > 0) begin
            wr_valid = 1'b1;
            wr_data  = wr_q[0];
            if (wr_ready) void'(wr_q.pop_front());
        end
    endtask

    // Offer a command and return one cycle after it is taken.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] l);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("cmd_accepted", 64'(cmd_ready), 64'(1));
        acc_cyc = cyc;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < limit) begin
            step();
            n++;
        end
        check("done_within_bound", 64'(done_cnt != base), 64'(1));
    endtask

    initial begin
        int b_done;
        int b_err;
        int b_rd;
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = '0;

        // Reset values
        step();
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_bus_req", 64'(bus_req), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_wr_ready", 64'(wr_ready), 64'(0));
        check("rst_bus_addr", 64'(bus_addr), 64'(0));
        rst_n = 1'b1;
        step();
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

        // Single-beat read, immediate ack: latency profile
        ack_en = 1'b1;
        ack_delay = 0;
        rsp_rd.push_back(32'hDEAD_BEEF);
        exp_rd.push_back(32'hDEAD_BEEF);
        exp_req.push_back('{32'h0000_0100, 1'b0, 32'h0, 0});
        b_done = done_cnt;
        b_err  = err_cnt;
        send_cmd(1'b0, 32'h0000_0100, 4'd0);
        check("t1_req_at_1", 64'(bus_req), 64'(1));
        check("t1_no_cmd_ready_busy", 64'(cmd_ready), 64'(0));
        repeat (3) step();
        check("t1_rd_latency", 64'(last_rd_cyc - acc_cyc), 64'(2));
        check("t1_done_latency", 64'(last_done_cyc - acc_cyc), 64'(3));
        check("t1_done_count", 64'(done_cnt - b_done), 64'(1));
        check("t1_no_err", 64'(err_cnt - b_err), 64'(0));
        check("t1_cmd_ready_at_4", 64'(cmd_ready), 64'(1));
        check("t1_rd_drained", 64'(exp_rd.size()), 64'(0));

        // Stray ack while idle has no effect
        b_rd = rd_cnt;
        b_done = done_cnt;
        ack_idle = 1'b1;
        repeat (3) step();
        ack_idle = 1'b0;
        step();
        step();
        check("idle_ack_no_rd", 64'(rd_cnt - b_rd), 64'(0));
        check("idle_ack_no_done", 64'(done_cnt - b_done), 64'(0));
        check("idle_ack_cmd_ready", 64'(cmd_ready), 64'(1));

        // Three-beat write, ack after 2 wait cycles per beat
        ack_delay = 2;
        wr_q.push_back(32'h11);
        wr_q.push_back(32'h22);
        wr_q.push_back(32'h33);
        exp_req.push_back('{32'h0000_0200, 1'b1, 32'h11, 0});
        exp_req.push_back('{32'h0000_0204, 1'b1, 32'h22, 2});
        exp_req.push_back('{32'h0000_0208, 1'b1, 32'h33, 2});
        b_done = done_cnt;
        b_err  = err_cnt;
        b_rd   = rd_cnt;
        send_cmd(1'b1, 32'h0000_0200, 4'd2);
        wait_done(80);
        step();
        step();
        check("t2_done_count", 64'(done_cnt - b_done), 64'(1));
        check("t2_no_err", 64'(err_cnt - b_err), 64'(0));
        check("t2_no_rd", 64'(rd_cnt - b_rd), 64'(0));
        check("t2_reqs_drained", 64'(exp_req.size()), 64'(0));
        check("t2_wr_drained", 64'(wr_q.size()), 64'(0));

        // Read with no ack: timeout
        ack_en = 1'b0;
        exp_req.push_back('{32'h0000_0300, 1'b0, 32'h0, 0});
        b_done = done_cnt;
        b_err  = err_cnt;
        send_cmd(1'b0, 32'h0000_0300, 4'd0);
        wait_done(400);
        check("t3_err_cycle", 64'(last_err_cyc - (acc_cyc + 1)), 64'(256));
        check("t3_done_with_err", 64'(last_done_cyc), 64'(last_err_cyc));
        check("t3_err_count", 64'(err_cnt - b_err), 64'(1));
        check("t3_bus_req_low", 64'(bus_req), 64'(0));
        step();
        check("t3_cmd_ready", 64'(cmd_ready), 64'(1));
        check("t3_err_single", 64'(err), 64'(0));
        ack_en = 1'b1;

        // Two-beat read across the top of the address space
        ack_delay = 1;
        rsp_rd.push_back(32'hAAAA_0001);
        rsp_rd.push_back(32'hAAAA_0002);
        exp_rd.push_back(32'hAAAA_0001);
        exp_rd.push_back(32'hAAAA_0002);
        exp_req.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0, 0});
        exp_req.push_back('{32'h0000_0000, 1'b0, 32'h0, 1});
        b_err = err_cnt;
        send_cmd(1'b0, 32'hFFFF_FFFC, 4'd1);
        wait_done(40);
        step();
        check("t4_reqs_drained", 64'(exp_req.size()), 64'(0));
        check("t4_rd_drained", 64'(exp_rd.size()), 64'(0));
        check("t4_no_err", 64'(err_cnt - b_err), 64'(0));

        // Reset in the middle of a four-beat read, right after beat 1 returns
        ack_delay = 0;
        rsp_rd.push_back(32'h5555_0001);
        exp_rd.push_back(32'h5555_0001);
        exp_req.push_back('{32'h0000_0400, 1'b0, 32'h0, 0});
        b_rd   = rd_cnt;
        b_done = done_cnt;
        b_err  = err_cnt;
        send_cmd(1'b0, 32'h0000_0400, 4'd3);
        n = 0;
        while (rd_cnt == b_rd && n < 20) begin
            step();
            n++;
        end
        check("t5_beat1_seen", 64'(rd_cnt - b_rd), 64'(1));
        rst_n = 1'b0;
        step();
        check("t5_bus_req_after_rst", 64'(bus_req), 64'(0));
        check("t5_rd_valid_after_rst", 64'(rd_valid), 64'(0));
        rst_n = 1'b1;
        step();
        check("t5_cmd_ready", 64'(cmd_ready), 64'(1));
        check("t5_bus_req_idle", 64'(bus_req), 64'(0));
        repeat (6) step();
        check("t5_no_done", 64'(done_cnt - b_done), 64'(0));
        check("t5_no_err", 64'(err_cnt - b_err), 64'(0));
        check("t5_rd_drained", 64'(exp_rd.size()), 64'(0));
        void'(rsp_rd.size());
        rsp_rd.delete();

        // Write with the data stream stalled for 10 cycles in FETCH
        ack_delay = 1;
        hold_wr = 1'b1;
        wr_q.push_back(32'hAA);
        wr_q.push_back(32'hBB);
        exp_req.push_back('{32'h0000_0500, 1'b1, 32'hAA, 0});
        exp_req.push_back('{32'h0000_0504, 1'b1, 32'hBB, 2});
        b_done = done_cnt;
        b_err  = err_cnt;
        send_cmd(1'b1, 32'h0000_0500, 4'd1);
        for (int i = 0; i < 10; i++) begin
            check("t6_stall_no_req", 64'(bus_req), 64'(0));
            check("t6_stall_no_err", 64'(err), 64'(0));
            check("t6_stall_wr_ready", 64'(wr_ready), 64'(1));
            step();
        end
        hold_wr = 1'b0;
        wait_done(60);
        step();
        check("t6_done_count", 64'(done_cnt - b_done), 64'(1));
        check("t6_no_err", 64'(err_cnt - b_err), 64'(0));
        check("t6_reqs_drained", 64'(exp_req.size()), 64'(0));
        check("t6_wr_drained", 64'(wr_q.size()), 64'(0));
        check("t6_cmd_ready", 64'(cmd_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
